multi_pulse_gen: RTL and testbench

//  N-channel successor to the single-channel one-shot pulse FSM. Each channel:
//  - synchronises an asynchronous level input
//  - debounces it
//  - detects a mode-selected edge
//  - emits a registered pulse of programmable width

---
 rtl/pulse_pkg.sv | 21 ++
 rtl/multi_pulse_gen_if.sv | 23 ++
 rtl/pulse_chan.sv | 134 +++++++++++++
 rtl/multi_pulse_gen.sv | 37 +++
 tb/tb_multi_pulse_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
// Shared constants for the multi-channel one-shot pulse generator:
// edge-select modes, per-channel FSM encodings and the edge qualification helper.
package pulse_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_GAP   = 2'b10
    } pulse_state_e;

    // Bit 0 of the mode enables rising edges, bit 1 enables falling edges
    function automatic logic edge_trig(input logic [1:0] mode, input logic rise, input logic fall);
        return (mode[0] & rise) | (mode[1] & fall);
    endfunction

endpackage

// File: rtl/multi_pulse_gen_if.sv
// Channel bus of the pulse generator: raw level inputs, mode selects and the
// per-channel pulse/level/overrun results plus the aggregate busy flag.
interface multi_pulse_gen_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   i_pulse;
    logic [2*N_CH-1:0] i_mode;
    logic              i_clr_ovr;
    logic [N_CH-1:0]   o_pulse;
    logic [N_CH-1:0]   o_level;
    logic [N_CH-1:0]   o_overrun;
    logic              o_busy;

    modport master (
        output i_pulse, i_mode, i_clr_ovr,
        input  o_pulse, o_level, o_overrun, o_busy
    );

    modport slave (
        input  i_pulse, i_mode, i_clr_ovr,
        output o_pulse, o_level, o_overrun, o_busy
    );
endinterface

// File: rtl/pulse_chan.sv
// One channel: synchroniser, debounce filter, mode-selected edge detect,
// IDLE/PULSE/GAP one-shot FSM and sticky overrun flag.
module pulse_chan
    import pulse_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int PULSE_W     = 1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       pulse_i,
    input  logic [1:0] mode_i,
    input  logic       clr_ovr_i,
    output logic       pulse_o,
    output logic       level_o,
    output logic       overrun_o,
    output logic       busy_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int WW = $clog2(PULSE_W + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q, filt_d, filt_dly_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    pulse_state_e           state_q, state_d;
    logic [WW-1:0]          wcnt_q, wcnt_d;
    logic                   pulse_q, pulse_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;
    logic                   s_s, rise_s, fall_s, trig_s;

    assign s_s    = sync_q[SYNC_STAGES-1];
    assign rise_s = filt_q & ~filt_dly_q;
    assign fall_s = ~filt_q & filt_dly_q;
    assign trig_s = edge_trig(mode_i, rise_s, fall_s);

    // Synchroniser chain, debounce filter state and previous-level history
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sync_q     <= '0;
            filt_q     <= 1'b0;
            cnt_q      <= '0;
            filt_dly_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pulse_i};
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            filt_dly_q <= filt_q;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s_s == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            filt_d = s_s;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // FSM next-state: GAP forces one low cycle between back-to-back pulses
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_s) begin
                    state_d = ST_PULSE;
                    wcnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (wcnt_q == WW'(PULSE_W - 1)) begin
                    state_d = ST_GAP;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values; a dropped edge beats a same-cycle clear
    always_comb begin
        pulse_d = (state_d == ST_PULSE);
        busy_d  = (state_d != ST_IDLE);
        if (trig_s && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end else if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Registered channel outputs
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pulse_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign pulse_o   = pulse_q;
    assign level_o   = filt_q;
    assign overrun_o = ovr_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// N-channel debounced edge-to-pulse generator: independent channels side by
// side, with a single busy flag covering all of them.
module multi_pulse_gen
    import pulse_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int PULSE_W     = 1
) (
    input  logic              Clock,
    input  logic              Resetn,
    multi_pulse_gen_if.slave  bus
);
    logic [N_CH-1:0] busy_s;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        pulse_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .PULSE_W     (PULSE_W)
        ) u_chan (
            .Clock     (Clock),
            .Resetn    (Resetn),
            .pulse_i   (bus.i_pulse[c]),
            .mode_i    (bus.i_mode[2*c+1 -: 2]),
            .clr_ovr_i (bus.i_clr_ovr),
            .pulse_o   (bus.o_pulse[c]),
            .level_o   (bus.o_level[c]),
            .overrun_o (bus.o_overrun[c]),
            .busy_o    (busy_s[c])
        );
    end

    assign bus.o_busy = |busy_s;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Bench for multi_pulse_gen: three instances (PULSE_W 1/3/8) share one stimulus
// stream and are compared every cycle against a timer-based behavioural model.
module tb_multi_pulse_gen;
    localparam int NC   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int ND   = 3;
    localparam int WID [ND] = '{1, 3, 8};

    logic Clock = 1'b0;
    logic Resetn;
    logic [NC-1:0]   tb_pulse;
    logic [2*NC-1:0] tb_mode;
    logic            tb_clr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 Clock = ~Clock;

    multi_pulse_gen_if #(.N_CH(NC)) bus0 ();
    multi_pulse_gen_if #(.N_CH(NC)) bus1 ();
    multi_pulse_gen_if #(.N_CH(NC)) bus2 ();

    assign bus0.i_pulse = tb_pulse; assign bus0.i_mode = tb_mode; assign bus0.i_clr_ovr = tb_clr;
    assign bus1.i_pulse = tb_pulse; assign bus1.i_mode = tb_mode; assign bus1.i_clr_ovr = tb_clr;
    assign bus2.i_pulse = tb_pulse; assign bus2.i_mode = tb_mode; assign bus2.i_clr_ovr = tb_clr;

    multi_pulse_gen #(.N_CH(NC), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .PULSE_W(1))
        dut0 (.Clock(Clock), .Resetn(Resetn), .bus(bus0));
    multi_pulse_gen #(.N_CH(NC), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .PULSE_W(3))
        dut1 (.Clock(Clock), .Resetn(Resetn), .bus(bus1));
    multi_pulse_gen #(.N_CH(NC), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .PULSE_W(8))
        dut2 (.Clock(Clock), .Resetn(Resetn), .bus(bus2));

    logic [NC-1:0] op [ND];
    logic [NC-1:0] ol [ND];
    logic [NC-1:0] oo [ND];
    logic          ob [ND];
    assign op[0] = bus0.o_pulse; assign ol[0] = bus0.o_level; assign oo[0] = bus0.o_overrun; assign ob[0] = bus0.o_busy;
    assign op[1] = bus1.o_pulse; assign ol[1] = bus1.o_level; assign oo[1] = bus1.o_overrun; assign ob[1] = bus1.o_busy;
    assign op[2] = bus2.o_pulse; assign ol[2] = bus2.o_level; assign oo[2] = bus2.o_overrun; assign ob[2] = bus2.o_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: input delay line, stable-run debounce, countdown timer per pulse
    bit sm   [NC][SYNC];
    int run  [NC];
    bit lev  [NC];
    bit levd [NC];
    int trem [ND][NC];
    bit movr [ND][NC];

    always @(posedge Clock) begin
        if (!Resetn) begin
            for (int c = 0; c < NC; c++) begin
                for (int k = 0; k < SYNC; k++) sm[c][k] = 1'b0;
                run[c] = 0; lev[c] = 1'b0; levd[c] = 1'b0;
                for (int d = 0; d < ND; d++) begin trem[d][c] = 0; movr[d][c] = 1'b0; end
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                bit s, l0, p0, tr, dropped;
                bit [1:0] md;
                s = sm[c][SYNC-1];
                for (int k = SYNC-1; k > 0; k--) sm[c][k] = sm[c][k-1];
                sm[c][0] = tb_pulse[c];
                l0 = lev[c]; p0 = levd[c]; md = tb_mode[2*c +: 2];
                tr = (md[0] && l0 && !p0) || (md[1] && !l0 && p0);
                levd[c] = l0;
                if (s != l0) begin
                    run[c]++;
                    if (run[c] == DEB) begin lev[c] = s; run[c] = 0; end
                end else begin
                    run[c] = 0;
                end
                for (int d = 0; d < ND; d++) begin
                    dropped = tr && (trem[d][c] != 0);
                    if (tr && trem[d][c] == 0) trem[d][c] = WID[d] + 1;
                    else if (trem[d][c] > 0) trem[d][c]--;
                    if (dropped) movr[d][c] = 1'b1;
                    else if (tb_clr) movr[d][c] = 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model
    always @(negedge Clock) begin
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                logic [NC-1:0] ep, el, eo;
                logic eb;
                eb = 1'b0;
                for (int c = 0; c < NC; c++) begin
                    ep[c] = (trem[d][c] > 1);
                    el[c] = lev[c];
                    eo[c] = movr[d][c];
                    if (trem[d][c] > 0) eb = 1'b1;
                end
                chk($sformatf("model_pulse d%0d", d), 32'(op[d]), 32'(ep));
                chk($sformatf("model_level d%0d", d), 32'(ol[d]), 32'(el));
                chk($sformatf("model_ovr d%0d", d), 32'(oo[d]), 32'(eo));
                chk($sformatf("model_busy d%0d", d), 32'(ob[d]), 32'(eb));
            end
        end
    end

    int rise_cnt;
    bit lvl_seen;

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic win(input int n, input int d, input int ch);
        bit p;
        p = op[d][ch];
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            if (op[d][ch] && !p) rise_cnt++;
            p = op[d][ch];
            if (ol[d][ch]) lvl_seen = 1'b1;
        end
    endtask

    task automatic win_clr();
        rise_cnt = 0;
        lvl_seen = 1'b0;
    endtask

    initial begin
        Resetn = 1'b0; tb_pulse = 4'hF; tb_mode = {4{2'b01}}; tb_clr = 1'b0;
        @(posedge Clock);
        #1 chk_en = 1'b1;

        // Reset held with all inputs high, then release into a rise on every channel
        tick(3);
        for (int d = 0; d < ND; d++) begin
            chk("rst_pulse", 32'(op[d]), 32'h0);
            chk("rst_level", 32'(ol[d]), 32'h0);
            chk("rst_ovr",   32'(oo[d]), 32'h0);
            chk("rst_busy",  32'(ob[d]), 32'h0);
        end
        Resetn = 1'b1;
        tick(7);
        chk("rel_pulse d0", 32'(op[0]), 32'hF);
        chk("rel_pulse d2", 32'(op[2]), 32'hF);
        tick(20);

        // Latency and width from a clean 0->1 on channel 0
        Resetn = 1'b0; tb_pulse = 4'h0;
        tick(2);
        Resetn = 1'b1; tb_pulse[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            chk($sformatf("lat_level k%0d", k), 32'(ol[1][0]), 32'(k >= 6));
            chk($sformatf("lat_w1 k%0d", k), 32'(op[0][0]), 32'(k == 7));
            chk($sformatf("lat_w3 k%0d", k), 32'(op[1][0]), 32'(k >= 7 && k <= 9));
            chk($sformatf("lat_w8 k%0d", k), 32'(op[2][0]), 32'(k >= 7 && k <= 14));
        end
        tick(5); tb_pulse[0] = 1'b0; tick(30);

        // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted
        win_clr(); tb_pulse[1] = 1'b1; win(3, 1, 1); tb_pulse[1] = 1'b0; win(20, 1, 1);
        chk("glitch_pulses", 32'(rise_cnt), 32'd0);
        chk("glitch_level",  32'(lvl_seen), 32'd0);
        win_clr(); tb_pulse[1] = 1'b1; win(4, 1, 1); tb_pulse[1] = 1'b0; win(25, 1, 1);
        chk("deb4_pulses", 32'(rise_cnt), 32'd1);
        chk("deb4_level",  32'(lvl_seen), 32'd1);

        // Mode select on channel 2
        tb_mode = {4{2'b11}};
        win_clr(); tb_pulse[2] = 1'b1; win(20, 1, 2); tb_pulse[2] = 1'b0; win(20, 1, 2);
        chk("mode_both", 32'(rise_cnt), 32'd2);
        tb_mode = {4{2'b10}};
        win_clr(); tb_pulse[2] = 1'b1; win(20, 1, 2); tb_pulse[2] = 1'b0; win(20, 1, 2);
        chk("mode_fall", 32'(rise_cnt), 32'd1);
        tb_mode = {4{2'b00}};
        win_clr(); tb_pulse[2] = 1'b1; win(20, 1, 2); tb_pulse[2] = 1'b0; win(20, 1, 2);
        chk("mode_off_pulses", 32'(rise_cnt), 32'd0);
        chk("mode_off_level",  32'(lvl_seen), 32'd1);

        // Overrun on the 8-wide instance, channel 3
        tb_mode = {4{2'b11}};
        win_clr(); tb_pulse[3] = 1'b1; win(5, 2, 3); tb_pulse[3] = 1'b0; win(30, 2, 3);
        chk("ovr_pulses", 32'(rise_cnt), 32'd1);
        chk("ovr_set",    32'(oo[2][3]), 32'd1);
        tb_clr = 1'b1; tick(1); tb_clr = 1'b0;
        chk("ovr_clr", 32'(oo[2][3]), 32'd0);
        tb_pulse[3] = 1'b1; tick(5); tb_pulse[3] = 1'b0; tick(6);
        tb_clr = 1'b1; tick(1); tb_clr = 1'b0;
        chk("ovr_set_wins", 32'(oo[2][3]), 32'd1);
        tick(30);

        // Reset in the second cycle of an 8-wide pulse
        tb_mode = {4{2'b01}};
        tb_pulse[0] = 1'b1; tick(8);
        chk("mid_pulse_on", 32'(op[2][0]), 32'd1);
        Resetn = 1'b0; tb_pulse = 4'h0; tick(1);
        chk("mid_rst_pulse", 32'(op[2][0]), 32'd0);
        chk("mid_rst_busy",  32'(ob[2]), 32'd0);
        Resetn = 1'b1;
        win_clr(); win(30, 2, 0);
        chk("post_rst_pulses", 32'(rise_cnt), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++)
                if ($urandom_range(0, 5) == 0) tb_pulse[c] = ~tb_pulse[c];
            if ($urandom_range(0, 49) == 0) tb_mode = 8'($urandom);
            tb_clr = ($urandom_range(0, 15) == 0);
            Resetn = ($urandom_range(0, 499) != 0);
            tick(1);
        end
        tb_clr = 1'b0; Resetn = 1'b1;
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
